output_bram_drainer: RTL and testbench

//  Drains accumulated results from the output/accumulation BRAM bank array into a serial stream.
//  - Drives the top level's external read port: ext_read_mode, ext_read_addr_flat, ext_read_data_flat.
//  - Reads one row (same address in all NUM_BRAMS banks), then serialises the row bank 0..NUM_BRAMS-1.
//  - Output is a valid/ready stream toward the DMA/host side. This block is the reader for the bank array.

---
 rtl/output_bram_drainer.sv | 165 ++++++++++++++++
 tb/tb_output_bram_drainer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_bram_drainer.sv
// Output bank drainer: reads one row across all banks, then
// serialises it bank 0..NUM_BRAMS-1 onto a valid/ready stream.
module output_bram_drainer #(
    parameter int DW        = 16,
    parameter int NUM_BRAMS = 16,
    parameter int O_ADDR_W  = 9,
    parameter int RD_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [O_ADDR_W-1:0]           base_addr,
    input  logic [O_ADDR_W:0]             num_rows,
    output logic                          busy,
    output logic                          done,
    output logic                          ext_read_mode,
    output logic [NUM_BRAMS*O_ADDR_W-1:0] ext_read_addr_flat,
    input  logic [NUM_BRAMS*DW-1:0]       ext_read_data_flat,
    output logic [DW-1:0]                 m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast
);

    localparam int CW = (NUM_BRAMS > 1) ? $clog2(NUM_BRAMS) : 1;
    localparam logic [CW-1:0]       COL_LAST = CW'(NUM_BRAMS - 1);
    localparam logic [CW-1:0]       COL_ONE  = CW'(1);
    localparam logic [O_ADDR_W:0]   ROW_ONE  = (O_ADDR_W + 1)'(1);
    localparam logic [O_ADDR_W-1:0] ADDR_ONE = O_ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        SEND,
        FIN
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [O_ADDR_W-1:0]   row_addr;
    logic [O_ADDR_W:0]     rows_left;
    logic [CW-1:0]         col;
    logic [1:0]            wait_cnt;
    logic [DW-1:0]         row_buf [NUM_BRAMS];
    logic                  beat;
    logic                  row_end;
    logic                  wait_end;
    logic                  reading;

    assign beat     = (state == SEND) && m_tready;
    assign row_end  = beat && (col == COL_LAST);
    assign wait_end = (int'(wait_cnt) + 2) >= RD_LAT;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nx           = state;
        reading            = 1'b0;
        busy               = 1'b0;
        done               = 1'b0;
        ext_read_mode      = 1'b0;
        ext_read_addr_flat = '0;
        m_tvalid           = 1'b0;
        m_tdata            = '0;
        m_tlast            = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (num_rows == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                reading  = 1'b1;
                state_nx = (RD_LAT > 1) ? WAIT : CAPTURE;
            end
            WAIT: begin
                reading = 1'b1;
                if (wait_end) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                reading  = 1'b1;
                state_nx = SEND;
            end
            SEND: begin
                reading  = 1'b1;
                m_tvalid = 1'b1;
                m_tdata  = row_buf[col];
                m_tlast  = (col == COL_LAST) && (rows_left == ROW_ONE);
                if (row_end) begin
                    state_nx = (rows_left == ROW_ONE) ? FIN : ISSUE;
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        busy          = reading;
        ext_read_mode = reading;
        if (reading) begin
            ext_read_addr_flat = {NUM_BRAMS{row_addr}};
        end
    end

    // Row address, row count, column index and the captured row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_addr  <= '0;
            rows_left <= '0;
            col       <= '0;
            wait_cnt  <= '0;
            for (int k = 0; k < NUM_BRAMS; k++) begin
                row_buf[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        row_addr  <= base_addr;
                        rows_left <= num_rows;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                end
                CAPTURE: begin
                    col <= '0;
                    for (int k = 0; k < NUM_BRAMS; k++) begin
                        row_buf[k] <= ext_read_data_flat[k*DW +: DW];
                    end
                end
                SEND: begin
                    if (row_end) begin
                        col       <= '0;
                        rows_left <= rows_left - ROW_ONE;
                        row_addr  <= row_addr + ADDR_ONE;
                    end else if (beat) begin
                        col <= col + COL_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_bram_drainer.sv
// Scoreboard bench for output_bram_drainer: three instances
// with read latency 1, 2 and 3 behind a modelled bank array.
`timescale 1ns/1ps
module tb_output_bram_drainer;

    localparam int DW = 16;
    localparam int NB = 16;
    localparam int AW = 9;
    localparam int NI = 3;

    typedef struct {
        int            inst;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    base_addr;
    logic [AW:0]      num_rows;
    logic             start  [NI];
    logic             ready  [NI];
    logic             busy   [NI];
    logic             done   [NI];
    logic             mode   [NI];
    logic             tvalid [NI];
    logic             tlast  [NI];
    logic [DW-1:0]    tdata  [NI];
    logic [NB*AW-1:0] raddr  [NI];

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    bit    tog = 1'b0;

    int   beats     [NI] = '{default: 0};
    int   lasts     [NI] = '{default: 0};
    int   mode_cyc  [NI] = '{default: 0};
    int   valid_cyc [NI] = '{default: 0};
    int   done_cnt  [NI] = '{default: 0};
    int   done_cyc  [NI] = '{default: 0};
    int   lbeat_cyc [NI] = '{default: 0};
    int   rise_cyc  [NI] = '{default: 0};
    logic prev_v    [NI] = '{default: 1'b0};
    logic hold      [NI] = '{default: 1'b0};
    logic hold_last [NI] = '{default: 1'b0};
    logic [DW-1:0] hold_data [NI] = '{default: '0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] word(input int a, input int k);
        return DW'(a * 256 + k * 17);
    endfunction

    function automatic logic [DW-1:0] bank_word(
        input logic m, input logic [AW-1:0] a, input int k);
        return m ? word(int'(a), k) : 16'hDEAD;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [AW:0]      pipe [3][NB];
        logic [NB*DW-1:0] rdata;

        output_bram_drainer #(
            .DW(DW), .NUM_BRAMS(NB), .O_ADDR_W(AW), .RD_LAT(g + 1)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .start(start[g]),
            .base_addr(base_addr),
            .num_rows(num_rows),
            .busy(busy[g]),
            .done(done[g]),
            .ext_read_mode(mode[g]),
            .ext_read_addr_flat(raddr[g]),
            .ext_read_data_flat(rdata),
            .m_tdata(tdata[g]),
            .m_tvalid(tvalid[g]),
            .m_tready(ready[g]),
            .m_tlast(tlast[g])
        );

        // bank array: each bank returns its word RD_LAT cycles after its address
        always @(posedge clk) begin
            for (int k = 0; k < NB; k++) begin
                pipe[0][k] <= {mode[g], raddr[g][k*AW +: AW]};
                pipe[1][k] <= pipe[0][k];
                pipe[2][k] <= pipe[1][k];
            end
        end

        always_comb begin
            rdata = '0;
            for (int k = 0; k < NB; k++) begin
                rdata[k*DW +: DW] =
                    bank_word(pipe[g][k][AW], pipe[g][k][AW-1:0], k);
            end
        end
    end

    // monitor: pops the scoreboard on every accepted beat
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            beat_t e;
            if (!rst_n) begin
                prev_v[i] = 1'b0;
                hold[i]   = 1'b0;
            end else begin
                if (mode[i]) mode_cyc[i]++;
                if (tvalid[i]) valid_cyc[i]++;
                if (tvalid[i] && !prev_v[i]) rise_cyc[i] = cyc;
                if (done[i]) begin
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                end
                if (hold[i]) begin
                    chk("stall_valid", tvalid[i], 1);
                    chk("stall_data", tdata[i], hold_data[i]);
                    chk("stall_last", tlast[i], hold_last[i]);
                end
                if (tvalid[i] && ready[i]) begin
                    beats[i]++;
                    lbeat_cyc[i] = cyc;
                    if (tlast[i]) lasts[i]++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL extra_beat: inst %0d data %0h expected none",
                                 i, tdata[i]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_inst", i, e.inst);
                        chk("beat_data", tdata[i], e.data);
                        chk("beat_last", tlast[i], e.last);
                    end
                end
                hold[i]      = tvalid[i] && !ready[i];
                hold_data[i] = tdata[i];
                hold_last[i] = tlast[i];
                prev_v[i]    = tvalid[i];
            end
        end
    end

    // backpressure on instance 0; the others always accept
    initial begin
        for (int i = 0; i < NI; i++) ready[i] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready[0] = tog ? ~ready[0] : 1'b1;
        end
    end

    task automatic check_zero(input int i, input string tag);
        chk({tag, "_busy"}, busy[i], 0);
        chk({tag, "_done"}, done[i], 0);
        chk({tag, "_mode"}, mode[i], 0);
        chk({tag, "_addr0"}, raddr[i][AW-1:0], 0);
        chk({tag, "_addr15"}, raddr[i][15*AW +: AW], 0);
        chk({tag, "_tdata"}, tdata[i], 0);
        chk({tag, "_tvalid"}, tvalid[i], 0);
        chk({tag, "_tlast"}, tlast[i], 0);
    endtask

    // present start for one cycle; t0 is the cycle start is driven
    task automatic go(input int i, input int base, input int rows,
                      output int t0);
        beat_t e;
        for (int r = 0; r < rows; r++) begin
            for (int k = 0; k < NB; k++) begin
                e.inst = i;
                e.data = word((base + r) % 512, k);
                e.last = (r == rows - 1) && (k == NB - 1);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        base_addr = AW'(base);
        num_rows  = (AW + 1)'(rows);
        start[i]  = 1'b1;
        t0        = cyc;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int n0;
        int k;
        n0 = done_cnt[i];
        k  = 0;
        while (done_cnt[i] == n0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("done_seen", done_cnt[i] - n0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        int b0;
        int l0;
        int m0;
        int v0;
        int d0;
        int k;
        rst_n     = 1'b0;
        base_addr = '0;
        num_rows  = '0;
        for (int i = 0; i < NI; i++) start[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero(0, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        // one row from address 0, no backpressure
        b0 = beats[0];
        go(0, 0, 1, t0);
        wait_done(0, 200);
        chk("t1_beats", beats[0] - b0, 16);
        chk("t1_latency", rise_cyc[0] - t0, 3);
        chk("t1_done_gap", done_cyc[0] - lbeat_cyc[0], 1);
        chk("t1_busy_low", busy[0], 0);

        // three rows with ready toggling every cycle
        tog = 1'b1;
        b0  = beats[0];
        l0  = lasts[0];
        go(0, 5, 3, t0);
        wait_done(0, 400);
        tog = 1'b0;
        chk("t2_beats", beats[0] - b0, 48);
        chk("t2_tlast_count", lasts[0] - l0, 1);

        // address wrap, plus a start that must be ignored mid-drain
        b0 = beats[0];
        d0 = done_cnt[0];
        go(0, 511, 2, t0);
        repeat (10) @(posedge clk);
        #1;
        base_addr = AW'(7);
        num_rows  = (AW + 1)'(4);
        start[0]  = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        wait_done(0, 300);
        repeat (30) @(posedge clk);
        #1;
        chk("t3_beats", beats[0] - b0, 32);
        chk("t3_done_count", done_cnt[0] - d0, 1);
        chk("t3_busy_low", busy[0], 0);
        chk("t3_queue_empty", exp_q.size(), 0);

        // zero rows: immediate done, no read, no beats
        m0 = mode_cyc[0];
        v0 = valid_cyc[0];
        go(0, 3, 0, t0);
        wait_done(0, 20);
        chk("t4_done_latency", done_cyc[0] - t0, 1);
        chk("t4_no_mode", mode_cyc[0] - m0, 0);
        chk("t4_no_valid", valid_cyc[0] - v0, 0);

        // reset while beat 7 of row 2 is on the bus
        b0 = beats[0];
        go(0, 20, 3, t0);
        k = 0;
        while (beats[0] < b0 + 22 && k < 500) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("t5_presenting_valid", tvalid[0], 1);
        chk("t5_presenting_data", tdata[0], word(21, 6));
        #1;
        rst_n = 1'b0;
        #1;
        check_zero(0, "t5_async");
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        b0 = beats[0];
        go(0, 40, 1, t0);
        wait_done(0, 200);
        chk("t5_beats", beats[0] - b0, 16);
        chk("t5_latency", rise_cyc[0] - t0, 3);

        // longer read latencies
        for (int i = 1; i < NI; i++) begin
            b0 = beats[i];
            go(i, 0, 1, t0);
            wait_done(i, 200);
            chk("t6_beats", beats[i] - b0, 16);
            chk("t6_latency", rise_cyc[i] - t0, 3 + i);
            chk("t6_done_gap", done_cyc[i] - lbeat_cyc[i], 1);
        end

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
